// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: IMEM request/response, redirect/stall control and decode delivery.
// master = fetch_queue side, slave = memory/decode/control side.
interface fetch_queue_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            IMEM_REQ_V;
    logic [XLEN-1:0] IMEM_REQ_ADDR;
    logic            IMEM_REQ_RDY;
    logic            IMEM_RSP_V;
    logic [ILEN-1:0] IMEM_RSP_DATA;
    logic            REDIRECT_V;
    logic [XLEN-1:0] REDIRECT_ADDR;
    logic            FE_BR_STALL;
    logic            DE_STALL;
    logic            DE_V;
    logic [ILEN-1:0] DE_IR;
    logic [XLEN-1:0] DE_NPC;

    modport master (
        output IMEM_REQ_V, IMEM_REQ_ADDR, DE_V, DE_IR, DE_NPC,
        input  IMEM_REQ_RDY, IMEM_RSP_V, IMEM_RSP_DATA,
        input  REDIRECT_V, REDIRECT_ADDR, FE_BR_STALL, DE_STALL
    );

    modport slave (
        input  IMEM_REQ_V, IMEM_REQ_ADDR, DE_V, DE_IR, DE_NPC,
        output IMEM_REQ_RDY, IMEM_RSP_V, IMEM_RSP_DATA,
        output REDIRECT_V, REDIRECT_ADDR, FE_BR_STALL, DE_STALL
    );
endinterface

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch with in-flight address FIFO and DEPTH-entry decode queue.
// Optional macro FE_PERF_CNT_EN adds saturating PERF_FETCHED / PERF_FLUSHED counters.
module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RESET_N,
    fetch_queue_if.master bus
`ifdef FE_PERF_CNT_EN
    ,
    output logic [31:0]   PERF_FETCHED,
    output logic [31:0]   PERF_FLUSHED
`endif
);
    localparam int QW = $clog2(DEPTH);
    localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(DEPTH + MAX_OUT) + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_q_ir  [DEPTH];
    logic [XLEN-1:0] r_q_npc [DEPTH];
    logic [QW-1:0]   r_q_wp, r_q_rp;
    logic [QW:0]     r_q_cnt;
    logic [XLEN-1:0] r_if_addr [MAX_OUT];
    logic [IW-1:0]   r_if_wp, r_if_rp;
    logic [IW:0]     r_if_cnt;
    logic [IW:0]     r_disc, w_disc_nxt;

    logic w_q_empty, w_de_v, w_pop, w_rsp, w_credit, w_req_v, w_acc, w_keep, w_drop;

    function automatic logic [IW-1:0] if_inc(input logic [IW-1:0] p);
        return (p == IW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts queued plus in-flight work so an accepted request always has a slot.
    assign w_q_empty = (r_q_cnt == '0);
    assign w_de_v    = !w_q_empty && !bus.FE_BR_STALL && !bus.REDIRECT_V;
    assign w_pop     = w_de_v && !bus.DE_STALL;
    assign w_rsp     = bus.IMEM_RSP_V && (r_if_cnt != '0);
    assign w_credit  = (CW'(r_q_cnt) + CW'(r_if_cnt) - CW'(w_pop)) < CW'(DEPTH);
    assign w_req_v   = RESET_N && !bus.REDIRECT_V && !bus.FE_BR_STALL && w_credit
                       && (r_if_cnt < (IW+1)'(MAX_OUT));
    assign w_acc     = w_req_v && bus.IMEM_REQ_RDY;
    assign w_keep    = w_rsp && (r_state == RUN) && !bus.REDIRECT_V;
    assign w_drop    = w_rsp && (r_state == DRAIN) && !bus.REDIRECT_V;

    assign bus.IMEM_REQ_V    = w_req_v;
    assign bus.IMEM_REQ_ADDR = r_pc;
    assign bus.DE_V          = w_de_v;
    assign bus.DE_IR         = w_q_empty ? '0 : r_q_ir[r_q_rp];
    assign bus.DE_NPC        = w_q_empty ? '0 : r_q_npc[r_q_rp];

    always_comb begin
        w_state_nxt = r_state;
        w_disc_nxt  = r_disc;
        if (bus.REDIRECT_V)
            w_disc_nxt = r_if_cnt - (IW+1)'(w_rsp);
        else if (w_drop)
            w_disc_nxt = r_disc - 1'b1;
        case (r_state)
            RUN:     if (w_disc_nxt != '0) w_state_nxt = DRAIN;
            DRAIN:   if (w_disc_nxt == '0) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= RUN;
            r_disc   <= '0;
            r_pc     <= RESET_PC;
            r_q_wp   <= '0;
            r_q_rp   <= '0;
            r_q_cnt  <= '0;
            r_if_wp  <= '0;
            r_if_rp  <= '0;
            r_if_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_disc  <= w_disc_nxt;
            if (bus.REDIRECT_V) begin
                r_pc    <= {bus.REDIRECT_ADDR[XLEN-1:2], 2'b00};
                r_q_wp  <= '0;
                r_q_rp  <= '0;
                r_q_cnt <= '0;
            end else begin
                if (w_acc)  r_pc   <= r_pc + XLEN'(4);
                if (w_keep) r_q_wp <= r_q_wp + 1'b1;
                if (w_pop)  r_q_rp <= r_q_rp + 1'b1;
                r_q_cnt <= r_q_cnt + (QW+1)'(w_keep) - (QW+1)'(w_pop);
            end
            // Wrong-path responses still pop here so later addresses line up.
            if (w_acc) r_if_wp <= if_inc(r_if_wp);
            if (w_rsp) r_if_rp <= if_inc(r_if_rp);
            r_if_cnt <= r_if_cnt + (IW+1)'(w_acc) - (IW+1)'(w_rsp);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_acc) r_if_addr[r_if_wp] <= r_pc;
        if (w_keep) begin
            r_q_ir[r_q_wp]  <= bus.IMEM_RSP_DATA;
            r_q_npc[r_q_wp] <= r_if_addr[r_if_rp] + XLEN'(4);
        end
    end

`ifdef FE_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] r_perf_fetched, r_perf_flushed, w_flush_inc;

    // A redirect drops the whole queue plus any response landing in that same cycle.
    assign w_flush_inc = bus.REDIRECT_V ? (32'(r_q_cnt) + 32'(w_rsp)) : 32'(w_drop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
        end else begin
            r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_keep));
            r_perf_flushed <= sat_add(r_perf_flushed, w_flush_inc);
        end
    end

    assign PERF_FETCHED = r_perf_fetched;
    assign PERF_FLUSHED = r_perf_flushed;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, decode stall, branch stall, redirect, PC wrap, mid-run reset.
module tb_fetch_queue;
    logic CLK = 1'b0;
    logic RESET_N;
    int   n_cmp = 0;
    int   n_err = 0;
    logic mem_hold = 1'b0;
    logic [63:0] exp_npc = 64'h4;
    logic [63:0] pend[$];

    fetch_queue_if #(.XLEN(64), .ILEN(32)) bus ();

`ifdef FE_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(64'h0)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
`ifdef FE_PERF_CNT_EN
        ,
        .PERF_FETCHED (perf_fetched),
        .PERF_FLUSHED (perf_flushed)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at settle, check any delivery, then model 1-cycle-latency IMEM.
    task automatic cyc();
        logic        acc;
        logic [63:0] a;
        #1;
        acc = bus.IMEM_REQ_V && bus.IMEM_REQ_RDY;
        a   = bus.IMEM_REQ_ADDR;
        if (bus.DE_V && !bus.DE_STALL) begin
            chk("deliver_npc", bus.DE_NPC, exp_npc);
            chk("deliver_ir", {32'h0, bus.DE_IR}, {32'h0, instr(exp_npc - 64'h4)});
            exp_npc = exp_npc + 64'h4;
        end
        @(posedge CLK);
        #1;
        if (acc) pend.push_back(a);
        if (!mem_hold && pend.size() > 0) begin
            bus.IMEM_RSP_V    = 1'b1;
            bus.IMEM_RSP_DATA = instr(pend.pop_front());
        end else begin
            bus.IMEM_RSP_V    = 1'b0;
            bus.IMEM_RSP_DATA = '0;
        end
        #1;
    endtask

    task automatic wait_de_v(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.DE_V) break;
            cyc();
        end
        #1;
    endtask

    initial begin
        RESET_N           = 1'b0;
        bus.IMEM_REQ_RDY  = 1'b1;
        bus.IMEM_RSP_V    = 1'b0;
        bus.IMEM_RSP_DATA = '0;
        bus.REDIRECT_V    = 1'b0;
        bus.REDIRECT_ADDR = '0;
        bus.FE_BR_STALL   = 1'b0;
        bus.DE_STALL      = 1'b0;
        #2;
        chk("rst_de_v", bus.DE_V, 0);
        chk("rst_de_ir", bus.DE_IR, 0);
        chk("rst_de_npc", bus.DE_NPC, 0);
        chk("rst_req_v", bus.IMEM_REQ_V, 0);
        chk("rst_pc", bus.IMEM_REQ_ADDR, 64'h0);

        // Streaming start
        @(posedge CLK); #2;
        RESET_N = 1'b1; #1;
        chk("s_req0_v", bus.IMEM_REQ_V, 1);
        chk("s_req0_addr", bus.IMEM_REQ_ADDR, 64'h0);
        cyc();
        chk("s_req1_addr", bus.IMEM_REQ_ADDR, 64'h4);
        chk("s_no_bypass", bus.DE_V, 0);
        cyc();
        chk("s_first_v", bus.DE_V, 1);
        chk("s_first_npc", bus.DE_NPC, 64'h4);
        chk("s_first_ir", bus.DE_IR, 64'hA5A5_0000);
        cyc();
        chk("s_npc8", bus.DE_NPC, 64'h8);
        cyc();
        chk("s_npcC", bus.DE_NPC, 64'hC);

        // Decode stall fills the queue to DEPTH
        bus.DE_STALL = 1'b1; #1;
        for (int i = 0; i < 10; i++) begin
            chk("ds_hold_npc", bus.DE_NPC, 64'hC);
            cyc();
        end
        chk("ds_req_v", bus.IMEM_REQ_V, 0);
        chk("ds_de_v", bus.DE_V, 1);
        chk("ds_ir", bus.DE_IR, 64'hA5A5_0008);
        chk("ds_pc", bus.IMEM_REQ_ADDR, 64'h18);
        bus.DE_STALL = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("ds_drain_v", bus.DE_V, 1);
            chk("ds_drain_npc", bus.DE_NPC, 64'hC + 64'(4 * i));
            cyc();
        end

        // Branch-pending stall
        bus.FE_BR_STALL = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("bs_de_v", bus.DE_V, 0);
            chk("bs_req_v", bus.IMEM_REQ_V, 0);
            cyc();
        end
        bus.FE_BR_STALL = 1'b0; #1;
        chk("bs_resume_npc", bus.DE_NPC, 64'h1C);
        for (int i = 0; i < 6; i++) cyc();

        // Redirect with two requests in flight
        mem_hold = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("rd_maxout", bus.IMEM_REQ_V, 0);
        chk("rd_pend2", 64'(pend.size()), 64'd2);
        bus.REDIRECT_V    = 1'b1;
        bus.REDIRECT_ADDR = 64'h1003; #1;
        chk("rd_cyc_req", bus.IMEM_REQ_V, 0);
        chk("rd_cyc_dev", bus.DE_V, 0);
        cyc();
        bus.REDIRECT_V = 1'b0;
        exp_npc = 64'h1004; #1;
        chk("rd_q_empty", bus.DE_V, 0);
        chk("rd_new_pc", bus.IMEM_REQ_ADDR, 64'h1000);
        mem_hold = 1'b0;
        wait_de_v(12);
        chk("rd_first_v", bus.DE_V, 1);
        chk("rd_first_npc", bus.DE_NPC, 64'h1004);
        chk("rd_first_ir", bus.DE_IR, 64'hA5A5_1000);
        for (int i = 0; i < 3; i++) cyc();

        // Redirect over a stalled, non-empty queue to the top of the address space
        bus.DE_STALL = 1'b1; #1;
        for (int i = 0; i < 3; i++) cyc();
        bus.REDIRECT_V    = 1'b1;
        bus.REDIRECT_ADDR = 64'hFFFF_FFFF_FFFF_FFFE; #1;
        cyc();
        bus.REDIRECT_V = 1'b0;
        bus.DE_STALL   = 1'b0;
        exp_npc = 64'h0; #1;
        chk("wr_flush", bus.DE_V, 0);
        chk("wr_pc", bus.IMEM_REQ_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        for (int i = 0; i < 10; i++) begin
            if (bus.IMEM_REQ_V) break;
            cyc();
        end
        chk("wr_req_v", bus.IMEM_REQ_V, 1);
        cyc();
        chk("wr_pc_wrap", bus.IMEM_REQ_ADDR, 64'h0);
        wait_de_v(12);
        chk("wr_first_npc", bus.DE_NPC, 64'h0);
        chk("wr_first_ir", bus.DE_IR, 64'h5A5A_FFFC);
        for (int i = 0; i < 4; i++) cyc();

        // Reset in the middle of a stream
        bus.DE_STALL = 1'b1; #1;
        for (int i = 0; i < 2; i++) cyc();
        chk("mr_pre_v", bus.DE_V, 1);
        mem_hold         = 1'b1;
        bus.IMEM_REQ_RDY = 1'b0;
        RESET_N          = 1'b0; #1;
        chk("mr_async_v", bus.DE_V, 0);
        chk("mr_async_npc", bus.DE_NPC, 0);
        chk("mr_async_ir", bus.DE_IR, 0);
        chk("mr_async_req", bus.IMEM_REQ_V, 0);
        cyc();
        RESET_N      = 1'b1;
        bus.DE_STALL = 1'b0;
        mem_hold     = 1'b0;
        pend.delete();
        bus.IMEM_RSP_V    = 1'b1;
        bus.IMEM_RSP_DATA = 32'hDEAD_BEEF; #1;
        chk("mr_pc", bus.IMEM_REQ_ADDR, 64'h0);
        chk("mr_req_v", bus.IMEM_REQ_V, 1);
        cyc();
        chk("mr_stale_ign", bus.DE_V, 0);
        bus.IMEM_REQ_RDY = 1'b1;
        exp_npc = 64'h4; #1;
        wait_de_v(8);
        chk("mr_first_v", bus.DE_V, 1);
        chk("mr_first_npc", bus.DE_NPC, 64'h4);
        chk("mr_first_ir", bus.DE_IR, 64'hA5A5_0000);
        for (int i = 0; i < 3; i++) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Generates sequential PCs and issues pipelined requests to instruction memory, up to MAX_OUT requests in flight.
- Buffers returned instructions, with their NPC, in a DEPTH-entry FIFO that feeds decode.
- Decouples fetch from decode stalls, holds fetch during branch resolution, and flushes wrong-path work on redirect.

Parameters:
- XLEN, 64: PC/address width.
- ILEN, 32: instruction width.
- DEPTH, 4: fetch-queue entries (power of 2, ≥2).
- MAX_OUT, 2: maximum outstanding IMEM requests (power of 2, ≥1).
- RESET_PC, 0: PC loaded at reset.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IMEM_REQ_V  out  1  request valid.
- IMEM_REQ_ADDR  out  XLEN  request address (the current PC).
- IMEM_REQ_RDY  in  1  memory accepts the request this cycle.
- IMEM_RSP_V  in  1  response valid; responses return in order, ≥1 cycle after acceptance.
- IMEM_RSP_DATA  in  ILEN  instruction word.
- REDIRECT_V  in  1  redirect fetch (taken branch/jump resolved).
- REDIRECT_ADDR  in  XLEN  new PC.
- FE_BR_STALL  in  1  OR of decode/execute/memory branch-pending stalls.
- DE_STALL  in  1  decode cannot accept (dependency stall).
- DE_V  out  1  DE_IR/DE_NPC are valid.
- DE_IR  out  ILEN  instruction at queue head.
- DE_NPC  out  XLEN  head instruction address + 4.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC; queue, in-flight FIFO and discard counter empty.
  - DE_V=0, DE_IR=0, DE_NPC=0, IMEM_REQ_V=0.
  - Assertion mid-operation clears everything immediately, including outstanding counts; responses that arrive after release are ignored because no request is recorded.
- Credit rule: IMEM_REQ_V = !REDIRECT_V && !FE_BR_STALL && (occupancy + outstanding − pops_this_cycle) < DEPTH && outstanding < MAX_OUT.
  - The queue can never overflow.
- Request accept (IMEM_REQ_V && IMEM_REQ_RDY):
  - PC += 4 at that edge, modulo 2^XLEN (wraps from all-ones−3 to 0).
  - The request address is pushed into the in-flight address FIFO (MAX_OUT entries).
- Response, when the discard counter is 0:
  - Pop the in-flight FIFO.
  - Push {addr+4, IMEM_RSP_DATA} into the queue.
  - Latency from response to DE_V is 1 cycle.
- Response, when the discard counter is >0:
  - Pop the in-flight FIFO, decrement the discard counter, and do not push.
- Output:
  - DE_V = queue non-empty && !FE_BR_STALL && !REDIRECT_V.
  - DE_IR/DE_NPC always show the head entry; they show 0 when the queue is empty.
  - The head is popped when DE_V && !DE_STALL.
  - With DE_STALL=1 the outputs hold stable.
- FE_BR_STALL:
  - Blocks new requests and masks DE_V.
  - Outstanding responses still land in the queue.
  - On deassertion without a redirect, fetch and delivery resume from the held PC and queue head.
- REDIRECT_V, which has priority over every other event in the same cycle:
  - At the edge the queue is emptied.
  - PC = {REDIRECT_ADDR[XLEN-1:2], 2'b00}.
  - Discard counter = in-flight count, excluding any response arriving in the same cycle (that response is dropped).
  - No request and no pop occur in the redirect cycle.
  - The first new-path request is issued the next cycle.
  - The in-flight FIFO keeps its contents so wrong-path responses pop correctly.
- Simultaneous push and pop on a full queue: allowed; occupancy is unchanged.
- Push into an empty queue with DE_STALL=0: the entry is visible the next cycle; there is no bypass.
- States:
  - RUN: discard counter = 0.
  - DRAIN: discard counter > 0; new requests are permitted in DRAIN.
  - RUN→DRAIN on a redirect with in-flight requests; DRAIN→RUN when the counter reaches 0.

Optional Feature:
- FE_PERF_CNT_EN defined: adds outputs PERF_FETCHED (32, count of queue pushes) and PERF_FLUSHED (32, queue entries plus discarded responses dropped by redirects).
  - Both counters are cleared by RESET_N and saturate at 2^32−1.
- FE_PERF_CNT_EN undefined: the ports and logic are absent; functional behaviour is identical.

Test Plan:
- Reset release, IMEM 1-cycle latency, DE_STALL=0 → requests at 0x0, 0x4, 0x8…; DE_V first high 2 cycles after the first accept with DE_NPC=0x4, then one instruction per cycle.
- DE_STALL held for 10 cycles with DEPTH=4 → exactly 4 entries buffered, IMEM_REQ_V low, DE_IR stable; on release the 4 entries drain in order with no gaps.
- FE_BR_STALL=1 for 3 cycles then 0 → DE_V=0 and no requests during the stall; resume at the held PC with no lost or duplicated instruction.
- REDIRECT_V with REDIRECT_ADDR=0x1003 while 2 requests are in flight → queue empty next cycle, the 2 late responses are dropped, the next request is at 0x1000, and the first DE_NPC is 0x1004.
- PC=0xFFFF_FFFF_FFFF_FFFC accepted → next request at 0x0; the first entry's DE_NPC=0x0.
- RESET_N asserted mid-stream with 3 queued entries → DE_V=0 asynchronously (before the next edge); after release fetch restarts at RESET_PC and stale responses are ignored.
